reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 22 ++
 rtl/reg_scoreboard_sb_entry.sv | 33 +++
 rtl/reg_scoreboard.sv | 63 ++++++
 tb/tb_reg_scoreboard.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard types; SCOREBOARD_BYPASS_EN relaxes the operand stall to cnt>1.
// Pure definitions, no timing or backpressure of its own.
package reg_scoreboard_pkg;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam int   REG_W    = 5;
  localparam int   LAT_W    = 3;
  localparam int   NUM_REGS = 1 << REG_W;

  typedef logic [LAT_W-1:0] cnt_t;

  // A countdown of 1 can be served by the forwarding network when bypass is built in.
  function automatic logic cnt_stalls(input cnt_t c);
`ifdef SCOREBOARD_BYPASS_EN
    return (c > cnt_t'(1)) ? ENABLE : DISABLE;
`else
    return (c != '0) ? ENABLE : DISABLE;
`endif
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry: one register's result countdown, priority flush > load > clear > decrement.
// Latency: state changes at the next clk edge; no backpressure, every request is applied.
module sb_entry
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_load,
  input  cnt_t i_lat,
  input  logic i_clr,
  output cnt_t o_cnt
);

  cnt_t r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_lat;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - cnt_t'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW decode stall; SCOREBOARD_BYPASS_EN lets cnt==1 operands issue.
// Latency: stall/ack are combinational; countdowns update at the next edge. Backpressure via stallD.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush,
  output logic             stall_rs,
  output logic             stall_rt,
  output logic             stallD,
  output logic             issue_ack,
  output logic [5:0]       pending_cnt,
  output logic [31:0]      busy_vec
);

  cnt_t w_cnt [NUM_REGS];
  logic w_waw;
  logic w_load_req;

  // r0 is hardwired: never pending, so it can never stall or be busy.
  assign w_cnt[0] = '0;

  assign w_load_req = issue_ack && (issue_lat != '0);

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    sb_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_load  (w_load_req && (issue_rd == REG_W'(g))),
      .i_lat   (issue_lat),
      .i_clr   (wb_valid && (wb_rd == REG_W'(g))),
      .o_cnt   (w_cnt[g])
    );
  end

  assign stall_rs = ((issue_rs != '0) && cnt_stalls(w_cnt[issue_rs])) ? ENABLE : DISABLE;
  assign stall_rt = ((issue_rt != '0) && cnt_stalls(w_cnt[issue_rt])) ? ENABLE : DISABLE;

  // WAW ignores bypass: a second writer must wait for the first to fully retire.
  assign w_waw = (issue_lat != '0) && (issue_rd != '0) && (w_cnt[issue_rd] != '0);

  assign stallD    = (issue_valid && (stall_rs || stall_rt || w_waw)) ? ENABLE : DISABLE;
  assign issue_ack = issue_valid && !stallD && !flush;

  always_comb begin
    busy_vec    = '0;
    pending_cnt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = (w_cnt[i] != '0);
      pending_cnt = pending_cnt + 6'(busy_vec[i]);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against an array-based countdown model.
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall_rs;
  logic        stall_rt;
  logic        stallD;
  logic        issue_ack;
  logic [5:0]  pending_cnt;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt [32] = '{default: 0};

`ifdef SCOREBOARD_BYPASS_EN
  localparam int RAW_STALL_CYC = 2;
`else
  localparam int RAW_STALL_CYC = 3;
`endif

  reg_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .stall_rs    (stall_rs),
    .stall_rt    (stall_rt),
    .stallD      (stallD),
    .issue_ack   (issue_ack),
    .pending_cnt (pending_cnt),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit m_stall(input int r);
    if (r == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    return m_cnt[r] > 1;
`else
    return m_cnt[r] != 0;
`endif
  endfunction

  function automatic bit m_stallD();
    return issue_valid && (m_stall(int'(issue_rs)) || m_stall(int'(issue_rt)) ||
           (issue_lat != 0 && issue_rd != 0 && m_cnt[issue_rd] != 0));
  endfunction

  function automatic bit m_ack();
    return issue_valid && !m_stallD() && !flush;
  endfunction

  // Reference: each register is an integer counting down to zero.
  always @(posedge clk or posedge reset) begin : model_upd
    bit ack;
    ack = m_ack();
    for (int r = 1; r < 32; r++) begin
      if (reset || flush)                                  m_cnt[r] = 0;
      else if (ack && issue_lat != 0 && int'(issue_rd) == r) m_cnt[r] = int'(issue_lat);
      else if (wb_valid && int'(wb_rd) == r)               m_cnt[r] = 0;
      else if (m_cnt[r] > 0)                               m_cnt[r] = m_cnt[r] - 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] eb;
    int          ep;
    eb = '0;
    ep = 0;
    for (int r = 1; r < 32; r++) begin
      eb[r] = (m_cnt[r] != 0);
      ep += (m_cnt[r] != 0) ? 1 : 0;
    end
    check("cmp_stall_rs", 32'(stall_rs), 32'(m_stall(int'(issue_rs))));
    check("cmp_stall_rt", 32'(stall_rt), 32'(m_stall(int'(issue_rt))));
    check("cmp_stallD", 32'(stallD), 32'(m_stallD()));
    check("cmp_issue_ack", 32'(issue_ack), 32'(m_ack()));
    check("cmp_busy_vec", busy_vec, eb);
    check("cmp_pending_cnt", 32'(pending_cnt), 32'(ep));
  end

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0; issue_rs = '0; issue_rt = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] lat,
                       input logic [4:0] rs, input logic [4:0] rt);
    issue_valid = 1'b1; issue_rd = rd; issue_lat = lat; issue_rs = rs; issue_rt = rt;
  endtask

  task automatic nexte();
    @(posedge clk);
    #1;
  endtask

  task automatic atneg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    nexte();
    nexte();
    issue(5'd0, 3'd0, 5'd0, 5'd0);
    atneg();
    check("rst_busy", busy_vec, 32'h0);
    check("rst_pending", 32'(pending_cnt), 32'd0);
    check("rst_stallD", 32'(stallD), 32'd0);
    check("rst_ack_follows_valid", 32'(issue_ack), 32'd1);
    nexte();
    reset = 1'b0;
    idle();
    nexte();

    // RAW on r5 with latency 3
    issue(5'd5, 3'd3, 5'd0, 5'd0);
    atneg(); check("raw_first_ack", 32'(issue_ack), 32'd1);
    nexte();
    issue(5'd0, 3'd0, 5'd5, 5'd0);
    for (int i = 0; i < RAW_STALL_CYC; i++) begin
      atneg();
      check("raw_stall_rs", 32'(stall_rs), 32'd1);
      check("raw_ack_blocked", 32'(issue_ack), 32'd0);
      nexte();
    end
    atneg();
    check("raw_stall_gone", 32'(stall_rs), 32'd0);
    check("raw_ack_after", 32'(issue_ack), 32'd1);
    nexte();
    idle();
    repeat (8) nexte();

    // r0 destination is never tracked
    issue(5'd0, 3'd7, 5'd0, 5'd0);
    atneg(); check("r0_ack", 32'(issue_ack), 32'd1);
    nexte();
    atneg();
    check("r0_busy", busy_vec, 32'h0);
    check("r0_pending", 32'(pending_cnt), 32'd0);
    check("r0_no_stall", 32'(stall_rs), 32'd0);
    nexte();
    idle();

    // writeback clears a pending count early
    issue(5'd9, 3'd2, 5'd0, 5'd0);
    nexte();
    issue(5'd0, 3'd0, 5'd9, 5'd0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    atneg();
    check("wb_stall_before", 32'(stall_rs), 32'd1);
    check("wb_busy_before", 32'(busy_vec[9]), 32'd1);
    nexte();
    wb_valid = 1'b0; wb_rd = '0;
    atneg();
    check("wb_busy_after", 32'(busy_vec[9]), 32'd0);
    check("wb_stall_after", 32'(stall_rs), 32'd0);
    nexte();
    idle();

    // WAW on r4
    issue(5'd4, 3'd3, 5'd0, 5'd0);
    nexte();
    issue(5'd4, 3'd2, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      atneg();
      check("waw_stallD", 32'(stallD), 32'd1);
      check("waw_ack_blocked", 32'(issue_ack), 32'd0);
      nexte();
    end
    atneg();
    check("waw_stallD_clear", 32'(stallD), 32'd0);
    check("waw_ack", 32'(issue_ack), 32'd1);
    nexte();
    idle();
    repeat (8) nexte();

    // flush with three pending registers
    issue(5'd1, 3'd7, 5'd0, 5'd0); nexte();
    issue(5'd2, 3'd7, 5'd0, 5'd0); nexte();
    issue(5'd3, 3'd7, 5'd0, 5'd0); nexte();
    issue(5'd7, 3'd4, 5'd0, 5'd0);
    flush = 1'b1;
    atneg();
    check("flush_pending_before", 32'(pending_cnt), 32'd3);
    check("flush_ack_blocked", 32'(issue_ack), 32'd0);
    nexte();
    idle();
    atneg();
    check("flush_pending_after", 32'(pending_cnt), 32'd0);
    check("flush_busy_after", busy_vec, 32'h0);
    nexte();

    // load beats writeback on the same edge
    issue(5'd12, 3'd5, 5'd0, 5'd0);
    wb_valid = 1'b1; wb_rd = 5'd12;
    atneg(); check("prio_ack", 32'(issue_ack), 32'd1);
    nexte();
    idle();
    for (int i = 0; i < 5; i++) begin
      atneg();
      check("prio_busy12", 32'(busy_vec[12]), 32'd1);
      nexte();
    end
    atneg(); check("prio_busy12_done", 32'(busy_vec[12]), 32'd0);
    nexte();

    // reset mid-countdown
    issue(5'd20, 3'd7, 5'd0, 5'd0);
    nexte();
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pending", 32'(pending_cnt), 32'd0);
    check("midrst_busy", busy_vec, 32'h0);
    nexte();
    reset = 1'b0;
    issue(5'd0, 3'd0, 5'd20, 5'd0);
    atneg();
    check("midrst_no_stall", 32'(stall_rs), 32'd0);
    check("midrst_ack", 32'(issue_ack), 32'd1);
    nexte();
    idle();

    // random traffic on a narrow register window to force collisions
    repeat (3000) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      issue_lat   = 3'($urandom_range(0, 7));
      issue_rs    = 5'($urandom_range(0, 7));
      issue_rt    = 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 3) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      nexte();
    end
    reset = 1'b0;
    idle();
    nexte();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
